mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage and consumes the same A/B operand buses.
- Executes MULT/MULTU/DIV/DIVU iteratively over 32 cycles and reports completion through a busy/done handshake.
- Serves MTHI/MTLO writes; HI/LO feed MFHI/MFLO through its outputs.

---
 rtl/mdu_hilo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo -- iterative multiply/divide unit with architectural HI/LO registers.
//
// Sits beside the execute-stage ALU and shares its A/B operand buses. A MULT,
// MULTU, DIV or DIVU runs as WIDTH radix-2 steps on operand magnitudes, then
// one fix-up cycle applies signs and special cases and writes HI/LO. The
// latency is fixed: for a start sampled at the edge that ends cycle t, busy is
// high in cycles t+1..t+33 and done pulses in cycle t+34 (WIDTH = 32).
//
// Optional build feature:
//   MDU_MADD_EN  when defined, op 100/101 (MADD/MADDU) add the signed/unsigned
//                product to the HI/LO pair modulo 2^(2*WIDTH). When undefined,
//                these codes are reserved and ignored.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset; aborts any operation
//   start  in   request an operation (ignored while busy or for reserved op)
//   op     in   3'b000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU
//   A      in   multiplicand / dividend / MTHI-MTLO data
//   B      in   multiplier / divisor
//   mthi   in   write A into HI (only when not busy)
//   mtlo   in   write A into LO (only when not busy)
//   busy   out  operation in progress
//   done   out  one-cycle pulse; HI/LO hold the new result
//   hi     out  HI register (remainder / upper product)
//   lo     out  LO register (quotient / lower product)
// -----------------------------------------------------------------------------
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMIN      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;

    // Iteration state. For multiply, {acc_hi, acc_lo} is the classic shift-add
    // product register with the multiplier shifting out of acc_lo. For divide,
    // acc_hi is the partial remainder and acc_lo shifts the dividend out while
    // the quotient bits shift in.
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;       // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] a_orig;     // raw A, returned in HI on divide-by-zero

    // Flags latched at start so FIX needs nothing from the operand buses.
    logic is_div;
    logic neg_q;                  // negate product / quotient
    logic neg_r;                  // negate remainder
    logic div_zero;
    logic div_ovf;
`ifdef MDU_MADD_EN
    logic is_madd;
`endif

    // -------------------------------------------------------------------------
    // Opcode decode
    // -------------------------------------------------------------------------
    logic op_valid;
    logic op_div;
    logic op_signed;
`ifdef MDU_MADD_EN
    logic op_madd;
`endif

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        op_valid  = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
`ifdef MDU_MADD_EN
        op_madd   = 1'b0;
`endif
        case (op)
            3'b000: begin op_valid = 1'b1; op_signed = 1'b1; end
            3'b001: begin op_valid = 1'b1; end
            3'b010: begin op_valid = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
            3'b011: begin op_valid = 1'b1; op_div = 1'b1; end
`ifdef MDU_MADD_EN
            3'b100: begin op_valid = 1'b1; op_signed = 1'b1; op_madd = 1'b1; end
            3'b101: begin op_valid = 1'b1; op_madd = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Operand magnitudes. Negating the most negative value yields the same bit
    // pattern, which is its correct unsigned magnitude.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_mag = (op_signed && A[WIDTH-1]) ? -A : A;
        b_mag = (op_signed && B[WIDTH-1]) ? -B : B;
    end

    // -------------------------------------------------------------------------
    // One radix-2 step
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole product register right by one including carry.
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        // Divide: shift remainder left, pulling in the next dividend bit, and
        // try subtracting the divisor. Bit WIDTH of the trial is the borrow.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};

        if (is_div) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // -------------------------------------------------------------------------
    // Sign correction and special cases applied in FIX
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_q) begin
            prod = -prod;
        end
`ifdef MDU_MADD_EN
        // HI/LO cannot change while busy, so the current pair is exactly the
        // value present once the start edge (and any MTHI/MTLO with it) landed.
        if (is_madd) begin
            prod = prod + {hi, lo};
        end
`endif
        quo = neg_q ? -acc_lo : acc_lo;
        rem = neg_r ? -acc_hi : acc_hi;

        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = a_orig;
                fix_lo = '1;
            end else if (div_ovf) begin
                fix_hi = '0;
                fix_lo = SMIN;
            end else begin
                fix_hi = rem;
                fix_lo = quo;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM, datapath registers and HI/LO
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_orig   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
`ifdef MDU_MADD_EN
            is_madd  <= 1'b0;
`endif
        end else begin
            // Register moves are honoured whenever no operation is in flight,
            // including the cycle that accepts a start.
            if (!busy) begin
                if (mthi) hi <= A;
                if (mtlo) lo <= A;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start && op_valid) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        count    <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= op_div ? a_mag : b_mag;
                        opnd     <= op_div ? b_mag : a_mag;
                        a_orig   <= A;
                        is_div   <= op_div;
                        neg_q    <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r    <= op_signed & op_div & A[WIDTH-1];
                        div_zero <= op_div & (B == '0);
                        div_ovf  <= op_div & op_signed & (A == SMIN) & (B == '1);
`ifdef MDU_MADD_EN
                        is_madd  <= op_madd;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo -- directed self-checking bench for mdu_hilo.
// Inputs are driven and outputs sampled 1 ns after each rising edge, so a
// sample taken in cycle k reflects the registers updated at the edge that
// started cycle k.
// -----------------------------------------------------------------------------
module tb_mdu_hilo;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    mdu_hilo #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation in the current cycle t and follow it to completion.
    // inj > 0 drives a DIVU start plus an MTHI of 5 in cycle t+inj, which the
    // busy unit must ignore.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic wr_hi, input logic wr_lo,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input int inj);
        int lat;
        int nb;
        lat   = 0;
        nb    = 0;
        op    = o;
        A     = a;
        B     = b;
        mthi  = wr_hi;
        mtlo  = wr_lo;
        start = 1'b1;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        A     = '0;
        B     = '0;
        op    = OP_MULT;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            if (inj > 0 && i == inj) begin
                start = 1'b1;
                op    = OP_DIVU;
                A     = 32'd5;
                B     = 32'd3;
                mthi  = 1'b1;
            end else if (inj > 0 && i == inj + 1) begin
                start = 1'b0;
                op    = OP_MULT;
                A     = '0;
                B     = '0;
                mthi  = 1'b0;
            end
            if (done) begin
                lat = i;
            end else begin
                if (busy) nb++;
                tick();
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " busy cycles"}, 64'(nb), 64'd33);
        check({tag, " busy low at done"}, {63'd0, busy}, 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        tick();
        check({tag, " done one cycle"}, {63'd0, done}, 64'd0);
    endtask

    // Start an op the unit must not accept; nothing may happen for 40 cycles.
    task automatic reject_op(input string tag, input logic [2:0] o);
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;
        int act;
        hi0   = hi;
        lo0   = lo;
        act   = 0;
        op    = o;
        A     = 32'd2;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (busy || done) act++;
            tick();
        end
        check({tag, " no activity"}, 64'(act), 64'd0);
        check({tag, " hi held"}, {32'd0, hi}, {32'd0, hi0});
        check({tag, " lo held"}, {32'd0, lo}, {32'd0, lo0});
    endtask

    task automatic write_hilo(input logic wr_hi, input logic wr_lo, input logic [W-1:0] val);
        mthi = wr_hi;
        mtlo = wr_lo;
        A    = val;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        A    = '0;
    endtask

    initial begin
        int seen;

        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        A     = '0;
        B     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);

        // Multiply
        run_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("mult -5*-6", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_001E, 0);
        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
               32'h4000_0000, 32'h0000_0000, 0);

        // Divide
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0,
               32'd2, 32'd14, 0);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0,
               32'd1, 32'hFFFF_FFFD, 0);
        run_op("divu by zero", OP_DIVU, 32'h0000_1234, 32'd0, 1'b0, 1'b0,
               32'h0000_1234, 32'hFFFF_FFFF, 0);
        run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'h0000_0000, 32'h8000_0000, 0);

        // Start and MTHI while busy are both ignored
        run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001, 10);
        write_hilo(1'b0, 1'b1, 32'h55);
        check("mtlo idle lo", {32'd0, lo}, 64'h55);
        check("mtlo idle hi kept", {32'd0, hi}, 64'hFFFF_FFFE);

        reject_op("reserved op", OP_RSVD);

        // Reset in the middle of a MULT: aborted, cleared, no done pulse
        op    = OP_MULT;
        A     = 32'd6;
        B     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        seen = 0;
        for (int i = 11; i <= 40; i++) begin
            if (done || busy) seen++;
            tick();
        end
        check("abort no done", 64'(seen), 64'd0);

`ifdef MDU_MADD_EN
        write_hilo(1'b1, 1'b0, 32'd0);
        write_hilo(1'b0, 1'b1, 32'd5);
        run_op("madd 5+2*3", OP_MADD, 32'd2, 32'd3, 1'b0, 1'b0,
               32'd0, 32'd11, 0);
        write_hilo(1'b1, 1'b1, 32'd0);
        run_op("madd 0+-1*1", OP_MADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        // Base is HI/LO after the MTHI/MTLO on the start edge: {2,2} + 6
        run_op("maddu base after write", OP_MADDU, 32'd2, 32'd3, 1'b1, 1'b1,
               32'd2, 32'd8, 0);
`else
        reject_op("madd reserved", OP_MADD);
        reject_op("maddu reserved", OP_MADDU);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
